// File: rtl/ctrl_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the pipeline main control unit: opcode and funct
// encodings, ALU function codes, datapath output-select codes, the
// multiply-sequencer state type and the decoded control bundle.
// ----------------------------------------------------------------------------
package ctrl_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;

    // ALU function codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_NOR = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Writeback result select
    localparam logic [1:0] OUT_ALU = 2'b00;
    localparam logic [1:0] OUT_LUI = 2'b01;
    localparam logic [1:0] OUT_LO  = 2'b10;
    localparam logic [1:0] OUT_HI  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mult_state_e;

    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       memwrite;
        logic       memtoreg;
        logic       se_ze;
        logic       branch_eq;
        logic       branch_ne;
        logic       jump;
        logic       is_mult;     // MULT or MULTU
        logic       mult_signed; // MULT (valid with is_mult)
        logic       uses_hilo;   // MULT/MULTU/MFHI/MFLO: subject to HI/LO hazard
        logic [3:0] aluctrl;
        logic [1:0] outselect;
        logic       illegal;
    } ctrl_t;

    // Bundle for "no operation": nothing written, no control transfer.
    function automatic ctrl_t ctrl_nop();
        ctrl_t c;
        c         = '0;
        c.aluctrl = ALU_ADD;
        return c;
    endfunction

endpackage

// File: rtl/control_unit_main_decoder.sv
// ----------------------------------------------------------------------------
// main_decoder
// Pure combinational op_code/funct to control-bundle decoder.
//   op_code : instr_d[31:26]
//   funct   : instr_d[5:0]
//   ctrl    : decoded control bundle (ctrl_pkg::ctrl_t)
// Unrecognised encodings give the nop bundle with illegal set.
// ----------------------------------------------------------------------------
module main_decoder
    import ctrl_pkg::*;
(
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    logic r_alu; // R-type ALU op: writes rd from the ALU

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        ctrl  = ctrl_nop();
        r_alu = 1'b0;
        case (op_code)
            OP_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: begin r_alu = 1'b1; ctrl.aluctrl = ALU_ADD; end
                    F_SUB:         begin r_alu = 1'b1; ctrl.aluctrl = ALU_SUB; end
                    F_AND:         begin r_alu = 1'b1; ctrl.aluctrl = ALU_AND; end
                    F_OR:          begin r_alu = 1'b1; ctrl.aluctrl = ALU_OR;  end
                    F_XOR:         begin r_alu = 1'b1; ctrl.aluctrl = ALU_XOR; end
                    F_NOR:         begin r_alu = 1'b1; ctrl.aluctrl = ALU_NOR; end
                    F_SLT:         begin r_alu = 1'b1; ctrl.aluctrl = ALU_SLT; end
                    F_MULT, F_MULTU: begin
                        ctrl.is_mult     = 1'b1;
                        ctrl.mult_signed = (funct == F_MULT);
                        ctrl.uses_hilo   = 1'b1;
                    end
                    F_MFHI, F_MFLO: begin
                        ctrl.regwrite  = 1'b1;
                        ctrl.regdst    = 1'b1;
                        ctrl.uses_hilo = 1'b1;
                        ctrl.outselect = (funct == F_MFHI) ? OUT_HI : OUT_LO;
                    end
                    default: ctrl.illegal = 1'b1;
                endcase
                if (r_alu) begin
                    ctrl.regwrite = 1'b1;
                    ctrl.regdst   = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.se_ze    = 1'b1;
                ctrl.aluctrl  = (op_code == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.aluctrl  = (op_code == OP_ANDI) ? ALU_AND :
                                (op_code == OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            OP_LUI: begin
                ctrl.regwrite  = 1'b1;
                ctrl.alusrc    = 1'b1;
                ctrl.outselect = OUT_LUI;
            end
            OP_LW: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.se_ze    = 1'b1;
            end
            OP_SW: begin
                ctrl.memwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.se_ze    = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.branch_eq = (op_code == OP_BEQ);
                ctrl.branch_ne = (op_code == OP_BNE);
                ctrl.se_ze     = 1'b1;
                ctrl.aluctrl   = ALU_SUB;
            end
            OP_J:    ctrl.jump    = 1'b1;
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ----------------------------------------------------------------------------
// control_unit
// Main decoder for the five-stage pipeline, multiply sequencer and pcsrc
// resolution. Optional macro: MULT_TIMEOUT_EN adds a multiply watchdog and the
// sticky mult_timeout output.
//   clk, reset         : clock (rising edge), async active-low reset
//   op_code, funct     : instruction fields in decode
//   eq_ne              : decode-stage operands equal
//   stall_d, flush_e   : decode held / execute register cleared at next edge
//   mult_done          : multiplier result valid (one-cycle pulse)
//   start_mult         : registered pulse during the execute cycle of MULT/MULTU
//   mult_sign          : registered signedness of the multiply in flight
//   pcsrc              : 00 pc+4, 01 branch, 1x jump
//   *_d, se_ze, output_branch, aluctrl_d, outselect_d : datapath controls
//   mult_busy          : sequencer not idle
//   mult_stall         : HI/LO hazard, decode must hold
//   illegal_op         : unrecognised opcode/funct
//   mult_timeout       : (MULT_TIMEOUT_EN) sticky watchdog flag
// ----------------------------------------------------------------------------
module control_unit
    import ctrl_pkg::*;
#(
    parameter int MULT_TIMEOUT = 64,
    parameter int CNT_W        = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    input  logic       eq_ne,
    input  logic       stall_d,
    input  logic       flush_e,
    input  logic       mult_done,
    output logic       start_mult,
    output logic       mult_sign,
    output logic [1:0] pcsrc,
    output logic       se_ze,
    output logic       regwrite_d,
    output logic       regdst_d,
    output logic       alusrc_d,
    output logic       memwrite_d,
    output logic       memtoreg_d,
    output logic       output_branch,
    output logic [3:0] aluctrl_d,
    output logic [1:0] outselect_d,
    output logic       mult_busy,
    output logic       mult_stall,
    output logic       illegal_op
`ifdef MULT_TIMEOUT_EN
    ,
    output logic       mult_timeout
`endif
);

    if (CNT_W < $clog2(MULT_TIMEOUT + 1)) begin : g_cnt_w_check
        $error("CNT_W too narrow for MULT_TIMEOUT");
    end

    ctrl_t       ctrl;
    mult_state_e state_q, state_d;
    logic        issue;
    logic        abort; // BUSY ends without a new issue

    main_decoder u_main_decoder (
        .op_code (op_code),
        .funct   (funct),
        .ctrl    (ctrl)
    );

    assign se_ze         = ctrl.se_ze;
    assign regwrite_d    = ctrl.regwrite;
    assign regdst_d      = ctrl.regdst;
    assign alusrc_d      = ctrl.alusrc;
    assign memwrite_d    = ctrl.memwrite;
    assign memtoreg_d    = ctrl.memtoreg;
    assign output_branch = ctrl.branch_eq | ctrl.branch_ne;
    assign aluctrl_d     = ctrl.aluctrl;
    assign outselect_d   = ctrl.outselect;
    assign illegal_op    = ctrl.illegal;

    // A completing multiply releases the hazard in the same cycle, so a
    // dependent or follow-on instruction proceeds without a bubble.
    assign mult_stall = ctrl.uses_hilo && (state_q == ST_BUSY) && !mult_done;
    assign issue      = ctrl.is_mult && !mult_stall && !stall_d && !flush_e;

`ifdef MULT_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_hit;

    assign timeout_hit = (state_q == ST_BUSY) && !mult_done &&
                         (cnt_q == CNT_W'(MULT_TIMEOUT - 1));
    assign abort       = (state_q == ST_BUSY) && (mult_done || timeout_hit) && !issue;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            mult_timeout <= 1'b0;
        end else begin
            if (issue)
                cnt_q <= '0;
            else if (state_q == ST_BUSY)
                cnt_q <= cnt_q + 1'b1;
            mult_timeout <= mult_timeout | timeout_hit;
        end
    end
`else
    assign abort = (state_q == ST_BUSY) && mult_done && !issue;
`endif

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (issue) state_d = ST_BUSY;
            ST_BUSY: if (abort) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered sequencer outputs: start pulse lines up with execute.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_mult <= 1'b0;
            mult_sign  <= 1'b0;
        end else begin
            start_mult <= issue;
            if (issue)
                mult_sign <= ctrl.mult_signed;
            else if (abort)
                mult_sign <= 1'b0;
        end
    end

    // Combinational outputs
    always_comb begin
        mult_busy = (state_q != ST_IDLE);
        pcsrc     = 2'b00;
        if (!mult_stall) begin
            if (ctrl.jump)
                pcsrc = 2'b10;
            else if ((ctrl.branch_eq && eq_ne) || (ctrl.branch_ne && !eq_ne))
                pcsrc = 2'b01;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// ----------------------------------------------------------------------------
// tb_control_unit
// Table-driven decode vectors plus directed multi-cycle sequences for the
// multiply sequencer. Inputs change 1 ns after the rising edge; outputs are
// sampled 1-2 ns after the edge, well before the next one.
// ----------------------------------------------------------------------------
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op_code, funct;
    logic       eq_ne, stall_d, flush_e, mult_done;
    logic       start_mult, mult_sign, se_ze, regwrite_d, regdst_d, alusrc_d;
    logic       memwrite_d, memtoreg_d, output_branch, mult_busy, mult_stall, illegal_op;
    logic [1:0] pcsrc, outselect_d;
    logic [3:0] aluctrl_d;
`ifdef MULT_TIMEOUT_EN
    logic       mult_timeout;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    control_unit #(.MULT_TIMEOUT(8), .CNT_W(7)) dut (
        .clk           (clk),
        .reset         (reset),
        .op_code       (op_code),
        .funct         (funct),
        .eq_ne         (eq_ne),
        .stall_d       (stall_d),
        .flush_e       (flush_e),
        .mult_done     (mult_done),
        .start_mult    (start_mult),
        .mult_sign     (mult_sign),
        .pcsrc         (pcsrc),
        .se_ze         (se_ze),
        .regwrite_d    (regwrite_d),
        .regdst_d      (regdst_d),
        .alusrc_d      (alusrc_d),
        .memwrite_d    (memwrite_d),
        .memtoreg_d    (memtoreg_d),
        .output_branch (output_branch),
        .aluctrl_d     (aluctrl_d),
        .outselect_d   (outselect_d),
        .mult_busy     (mult_busy),
        .mult_stall    (mult_stall),
        .illegal_op    (illegal_op)
`ifdef MULT_TIMEOUT_EN
        ,
        .mult_timeout  (mult_timeout)
`endif
    );

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       eq;
        logic [1:0] pc;
        logic       se, rw, rd, as, mw, mr, br;
        logic [3:0] alu;
        logic [1:0] outs;
        logic       ill;
        logic       chk_se, chk_alu; // 0 where the field is a don't-care
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic eq,
                         input logic st, input logic fl, input logic dn);
        op_code   = op;
        funct     = fn;
        eq_ne     = eq;
        stall_d   = st;
        flush_e   = fl;
        mult_done = dn;
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] act, exp;
        int          bad;

        //            name     op         fn         eq pc    se rw rd as mw mr br alu      out   il cse calu
        vecs.push_back('{"add",   6'o00, 6'b100000, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 1});
        vecs.push_back('{"addu",  6'o00, 6'b100001, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 1});
        vecs.push_back('{"sub",   6'o00, 6'b100010, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 4'b0110, 2'b00, 0, 0, 1});
        vecs.push_back('{"and",   6'o00, 6'b100100, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 1});
        vecs.push_back('{"or",    6'o00, 6'b100101, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 4'b0001, 2'b00, 0, 0, 1});
        vecs.push_back('{"xor",   6'o00, 6'b100110, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 4'b0011, 2'b00, 0, 0, 1});
        vecs.push_back('{"nor",   6'o00, 6'b100111, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 4'b0100, 2'b00, 0, 0, 1});
        vecs.push_back('{"slt",   6'o00, 6'b101010, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 4'b0111, 2'b00, 0, 0, 1});
        vecs.push_back('{"mfhi",  6'o00, 6'b010000, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 4'b0000, 2'b11, 0, 0, 0});
        vecs.push_back('{"mflo",  6'o00, 6'b010010, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 4'b0000, 2'b10, 0, 0, 0});
        vecs.push_back('{"mult",  6'o00, 6'b011000, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 0});
        vecs.push_back('{"multu", 6'o00, 6'b011001, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 0});
        vecs.push_back('{"r_ill", 6'o00, 6'b000001, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 1, 0, 0});
        vecs.push_back('{"addi",  6'b001000, 6'h0, 0, 2'b00, 1, 1, 0, 1, 0, 0, 0, 4'b0010, 2'b00, 0, 1, 1});
        vecs.push_back('{"addiu", 6'b001001, 6'h0, 0, 2'b00, 1, 1, 0, 1, 0, 0, 0, 4'b0010, 2'b00, 0, 1, 1});
        vecs.push_back('{"slti",  6'b001010, 6'h0, 0, 2'b00, 1, 1, 0, 1, 0, 0, 0, 4'b0111, 2'b00, 0, 1, 1});
        vecs.push_back('{"andi",  6'b001100, 6'h0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 4'b0000, 2'b00, 0, 1, 1});
        vecs.push_back('{"ori",   6'b001101, 6'h0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 4'b0001, 2'b00, 0, 1, 1});
        vecs.push_back('{"xori",  6'b001110, 6'h0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 4'b0011, 2'b00, 0, 1, 1});
        vecs.push_back('{"lui",   6'b001111, 6'h0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 4'b0000, 2'b01, 0, 0, 0});
        vecs.push_back('{"lw",    6'b100011, 6'h0, 0, 2'b00, 1, 1, 0, 1, 0, 1, 0, 4'b0010, 2'b00, 0, 1, 1});
        vecs.push_back('{"sw",    6'b101011, 6'h0, 0, 2'b00, 1, 0, 0, 1, 1, 0, 0, 4'b0010, 2'b00, 0, 1, 1});
        vecs.push_back('{"beq_t", 6'b000100, 6'h0, 1, 2'b01, 1, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b00, 0, 1, 0});
        vecs.push_back('{"beq_n", 6'b000100, 6'h0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b00, 0, 1, 0});
        vecs.push_back('{"bne_t", 6'b000101, 6'h0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b00, 0, 1, 0});
        vecs.push_back('{"bne_n", 6'b000101, 6'h0, 1, 2'b00, 1, 0, 0, 0, 0, 0, 1, 4'b0000, 2'b00, 0, 1, 0});
        vecs.push_back('{"j_0",   6'b000010, 6'h0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 0});
        vecs.push_back('{"j_1",   6'b000010, 6'h0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 0});
        vecs.push_back('{"ill",   6'b111111, 6'h0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 2'b00, 1, 0, 0});

        // ---- Reset: held low for 3 cycles with ADD in decode ----
        reset = 1'b0;
        drive(6'b000000, 6'b100000, 0, 0, 0, 0);
        #2;
        check("rst_outputs", {29'd0, start_mult, mult_sign, mult_busy}, 32'd0);
        repeat (3) tick();
        check("rst_outputs_held", {29'd0, start_mult, mult_sign, mult_busy}, 32'd0);
        reset = 1'b1;
        tick();
        check("post_rst_add", {25'd0, regwrite_d, regdst_d, aluctrl_d, outselect_d},
              {25'd0, 1'b1, 1'b1, 4'b0010, 2'b00});
        check("post_rst_idle", {30'd0, start_mult, mult_busy}, 32'd0);

        // ---- Decode table (flush_e keeps MULT/MULTU from issuing) ----
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].fn, vecs[i].eq, 0, 1, 0);
            #1;
            act = {pcsrc, se_ze & vecs[i].chk_se, regwrite_d, regdst_d, alusrc_d, memwrite_d,
                   memtoreg_d, output_branch, aluctrl_d & {4{vecs[i].chk_alu}}, outselect_d, illegal_op};
            exp = {vecs[i].pc, vecs[i].se & vecs[i].chk_se, vecs[i].rw, vecs[i].rd, vecs[i].as,
                   vecs[i].mw, vecs[i].mr, vecs[i].br, vecs[i].alu & {4{vecs[i].chk_alu}},
                   vecs[i].outs, vecs[i].ill};
            check(vecs[i].name, 32'(act), 32'(exp));
            tick();
        end
        // MULT/MULTU above were flushed: sequencer must still be idle.
        check("flush_no_issue", {30'd0, start_mult, mult_busy}, 32'd0);

        // ---- MULT at cycle N, MFLO waits on HI/LO, mult_done at N+33 ----
        drive(6'b000000, 6'b011000, 0, 0, 0, 0);       // cycle N
        #1;
        check("mult_n_nostall", {31'd0, mult_stall}, 32'd0);
        check("mult_n_nostart", {31'd0, start_mult}, 32'd0);
        tick();                                         // cycle N+1
        check("mult_issue", {29'd0, start_mult, mult_sign, mult_busy}, 32'd7);
        drive(6'b000000, 6'b100000, 0, 0, 0, 0);
        tick();                                         // N+2
        check("mult_pulse_one", {30'd0, start_mult, mult_busy}, 32'd1);
        tick(); tick();                                 // N+4
        bad = 0;
        for (int c = 5; c <= 32; c++) begin
            tick();                                     // N+c
            drive(6'b000000, 6'b010010, 0, 0, 0, 0);
            #1;
            if (mult_stall !== 1'b1 || mult_busy !== 1'b1 || start_mult !== 1'b0 ||
                mult_sign !== 1'b1 || pcsrc !== 2'b00) bad++;
        end
        check("mflo_stall_cycles", 32'(bad), 32'd0);
        tick();                                         // N+33
        drive(6'b000000, 6'b010010, 0, 0, 0, 1);
        #1;
        check("mflo_done_nostall", {29'd0, mult_stall, outselect_d}, {29'd0, 1'b0, 2'b10});
        tick();                                         // N+34
        drive(6'b000000, 6'b100000, 0, 0, 0, 0);
        check("mult_retire", {29'd0, mult_busy, mult_sign, start_mult}, 32'd0);

        // ---- Stray mult_done in IDLE is ignored ----
        drive(6'b000000, 6'b100000, 0, 0, 0, 1);
        tick();
        drive(6'b000000, 6'b100000, 0, 0, 0, 0);
        check("stray_done", {30'd0, mult_busy, start_mult}, 32'd0);

        // ---- MULTU, then MULT decoded in the mult_done cycle issues next edge ----
        drive(6'b000000, 6'b011001, 0, 0, 0, 0);
        tick();
        check("multu_issue", {29'd0, start_mult, mult_sign, mult_busy}, 32'b101);
        drive(6'b000000, 6'b011000, 0, 0, 0, 0);
        #1;
        check("mult_behind_stall", {30'd0, mult_stall, mult_busy}, 32'b11);
        tick();
        check("mult_behind_held", {30'd0, start_mult, mult_sign}, 32'd0);
        drive(6'b000000, 6'b011000, 0, 0, 0, 1);
        #1;
        check("mult_on_done_nostall", {31'd0, mult_stall}, 32'd0);
        tick();
        drive(6'b000000, 6'b100000, 0, 0, 0, 0);
        check("mult_on_done_issue", {29'd0, start_mult, mult_sign, mult_busy}, 32'd7);

        // ---- Reset mid-BUSY clears immediately ----
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_busy", {29'd0, mult_busy, start_mult, mult_sign}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_busy_idle", {31'd0, mult_busy}, 32'd0);

        // ---- MULTU with flush_e, then with stall_d: no issue ----
        drive(6'b000000, 6'b011001, 0, 0, 1, 0);
        tick();
        check("multu_flush", {30'd0, start_mult, mult_busy}, 32'd0);
        drive(6'b000000, 6'b011001, 0, 1, 0, 0);
        tick();
        check("multu_stall_d", {30'd0, start_mult, mult_busy}, 32'd0);
        drive(6'b000000, 6'b100000, 0, 0, 0, 0);

`ifdef MULT_TIMEOUT_EN
        // ---- Watchdog: MULT with no mult_done, MULT_TIMEOUT = 8 ----
        check("to_clear", {31'd0, mult_timeout}, 32'd0);
        drive(6'b000000, 6'b011000, 0, 0, 0, 0);
        tick();                                         // issue edge
        drive(6'b000000, 6'b100000, 0, 0, 0, 0);
        bad = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (mult_busy !== 1'b1 || mult_timeout !== 1'b0) bad++;
        end
        check("to_busy_window", 32'(bad), 32'd0);
        tick();                                         // 8 cycles after issue
        check("to_fired", {30'd0, mult_timeout, mult_busy}, 32'b10);
        repeat (2) tick();
        check("to_sticky", {31'd0, mult_timeout}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
